// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory access controller and the CPU
// writeback path: access-size encodings, FSM state encoding, requester
// indices, the latched request record and the alignment/legality check.
// -----------------------------------------------------------------------------
package dm_pkg;

    // Access size encodings (match the memory's Saveop input)
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Requester indices
    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dm_state_e;

    // Request fields captured in the grant cycle
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wdata;
    } dm_req_t;

    // A request is illegal when its size is reserved or it is not naturally
    // aligned for its size.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] laddr);
        logic ill;
        case (size)
            SZ_WORD: ill = (laddr != 2'b00);
            SZ_HALF: ill = laddr[0];
            SZ_BYTE: ill = 1'b0;
            default: ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_arbiter_if
// Bundles both requester ports (m0 = CPU load/store, m1 = loader/debug) and
// the data-memory control port of dm_arbiter.
//   slave  : the arbiter side (receives requests, drives memory controls)
//   master : the requester/memory side (drives requests and dm_dout)
// -----------------------------------------------------------------------------
interface dm_arbiter_if;

    // Requester 0 (CPU)
    logic        m0_req;
    logic        m0_we;
    logic [1:0]  m0_size;
    logic        m0_uns;
    logic [11:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic        m0_err;
    logic [31:0] m0_rdata;

    // Requester 1 (loader/debug)
    logic        m1_req;
    logic        m1_we;
    logic [1:0]  m1_size;
    logic        m1_uns;
    logic [11:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic        m1_err;
    logic [31:0] m1_rdata;

    // Data memory controls
    logic [9:0]  dm_addr;
    logic [1:0]  dm_laddr;
    logic [31:0] dm_din;
    logic        dm_MemRead;
    logic        dm_MemWrite;
    logic [1:0]  dm_Saveop;
    logic [31:0] dm_dout;

    modport slave (
        input  m0_req, m0_we, m0_size, m0_uns, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_size, m1_uns, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_err, m1_rdata,
        output dm_addr, dm_laddr, dm_din, dm_MemRead, dm_MemWrite, dm_Saveop,
        input  dm_dout
    );

    modport master (
        output m0_req, m0_we, m0_size, m0_uns, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_err, m0_rdata,
        output m1_req, m1_we, m1_size, m1_uns, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_err, m1_rdata,
        input  dm_addr, dm_laddr, dm_din, dm_MemRead, dm_MemWrite, dm_Saveop,
        output dm_dout
    );

endinterface

// File: rtl/dm_load_ext.sv
// -----------------------------------------------------------------------------
// dm_load_ext
// Combinational load-lane extraction with sign/zero extension.
//   word_i  : full 32-bit memory word
//   size_i  : access size (SZ_WORD / SZ_BYTE / SZ_HALF)
//   uns_i   : 1 = zero-extend, 0 = sign-extend
//   laddr_i : byte offset within the word
//   rdata_o : extended result
// -----------------------------------------------------------------------------
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [1:0]  laddr_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = word_i[{laddr_i, 3'b000} +: 8];
    assign half_lane = laddr_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        rdata_o = word_i;
        case (size_i)
            SZ_BYTE: rdata_o = {{24{~uns_i & byte_lane[7]}}, byte_lane};
            SZ_HALF: rdata_o = {{16{~uns_i & half_lane[15]}}, half_lane};
            default: rdata_o = word_i;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Two-requester access controller for the 4 KB single-port data memory.
// Each access runs IDLE/RESP (grant) -> ACCESS (memory cycle) -> RESP.
//   RR   : 1 = round-robin on ties, 0 = m0 always wins
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : requester ports m0/m1 and memory controls (dm_arbiter_if.slave)
// Grants are combinational in IDLE/RESP; all other outputs derive from
// registered state. Illegal requests are granted but never enable memory.
// -----------------------------------------------------------------------------
module dm_arbiter
    import dm_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    dm_arbiter_if.slave  bus
);

    dm_state_e   state_q;
    logic        last_grant_q;
    logic        owner_q;
    dm_req_t     lat_q;
    logic        illegal_q;
    logic [31:0] word_q;

    logic [1:0]  req;
    dm_req_t     req_fields [2];
    logic        grant_ok;
    logic        winner;
    dm_req_t     win_fields;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [1:0]  err;
    logic [31:0] rdata [2];
    logic        in_access;
    logic        in_resp;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] ext_data;

    assign req = {bus.m1_req, bus.m0_req};

    assign req_fields[0] = '{we: bus.m0_we, size: bus.m0_size, uns: bus.m0_uns,
                             addr: bus.m0_addr, wdata: bus.m0_wdata};
    assign req_fields[1] = '{we: bus.m1_we, size: bus.m1_size, uns: bus.m1_uns,
                             addr: bus.m1_addr, wdata: bus.m1_wdata};

    // Grants are suppressed while reset is asserted so nothing is latched
    // that the reset would then discard.
    assign grant_ok = rst && ((state_q == ST_IDLE) || (state_q == ST_RESP)) && (|req);

    // m1 wins when alone, or on a tie in round-robin mode when m0 had the
    // last grant.
    assign winner     = (req[1] && (!req[0] || (RR && (last_grant_q == M_CPU)))) ? M_DBG : M_CPU;
    assign win_fields = winner ? req_fields[1] : req_fields[0];

    assign in_access = (state_q == ST_ACCESS);
    assign in_resp   = (state_q == ST_RESP);
    assign mem_rd    = in_access && !illegal_q && !lat_q.we;
    assign mem_wr    = in_access && !illegal_q &&  lat_q.we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= M_DBG;
            owner_q      <= M_CPU;
            lat_q        <= '0;
            illegal_q    <= 1'b0;
            word_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (grant_ok) begin
                        state_q      <= ST_ACCESS;
                        owner_q      <= winner;
                        last_grant_q <= winner;
                        lat_q        <= win_fields;
                        illegal_q    <= is_illegal(win_fields.size, win_fields.addr[1:0]);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_RESP;
                    // Read data is only meaningful for legal loads
                    word_q  <= mem_rd ? bus.dm_dout : '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    dm_load_ext u_load_ext (
        .word_i  (word_q),
        .size_i  (lat_q.size),
        .uns_i   (lat_q.uns),
        .laddr_i (lat_q.addr[1:0]),
        .rdata_o (ext_data)
    );

    // Per-requester grant and response routing
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            localparam logic IDX = (gi == 1);
            assign gnt[gi]    = grant_ok && (winner == IDX);
            assign rvalid[gi] = in_resp && (owner_q == IDX);
            assign err[gi]    = rvalid[gi] && illegal_q;
            assign rdata[gi]  = (rvalid[gi] && !illegal_q && !lat_q.we) ? ext_data : '0;
        end
    endgenerate

    assign bus.m0_gnt    = gnt[0];
    assign bus.m0_rvalid = rvalid[0];
    assign bus.m0_err    = err[0];
    assign bus.m0_rdata  = rdata[0];
    assign bus.m1_gnt    = gnt[1];
    assign bus.m1_rvalid = rvalid[1];
    assign bus.m1_err    = err[1];
    assign bus.m1_rdata  = rdata[1];

    // Address/data are presented for every access cycle; only the enables
    // are withheld for illegal requests.
    assign bus.dm_addr     = in_access ? lat_q.addr[11:2] : '0;
    assign bus.dm_laddr    = in_access ? lat_q.addr[1:0]  : '0;
    assign bus.dm_din      = in_access ? lat_q.wdata      : '0;
    assign bus.dm_Saveop   = in_access ? lat_q.size       : '0;
    assign bus.dm_MemRead  = mem_rd;
    assign bus.dm_MemWrite = mem_wr;

endmodule
